// File: rtl/en2_level_pkg.sv
// rtl/en2_level_pkg.sv - shared types and helpers for the enable-to-level block
package en2level_pkg;

  typedef enum logic [1:0] {
    LOW_HOLD  = 2'd0,
    LOW       = 2'd1,
    HIGH_HOLD = 2'd2,
    HIGH      = 2'd3
  } state_t;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/en2_level_if.sv
// rtl/en2_level_if.sv - rise/fall request inputs and level/status outputs
interface en2_level_if;
  logic en_rise;
  logic en_fall;
  logic out;
  logic busy;
  logic err;

  modport master (output en_rise, output en_fall, input out, input busy, input err);
  modport slave  (input en_rise, input en_fall, output out, output busy, output err);
endinterface

// File: rtl/en2_level_sync_delay.sv
// rtl/en2_level_sync_delay.sv - 1-bit shift register of DEPTH stages, DEPTH=0 is a wire
module sync_delay #(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  generate
    if (DEPTH == 0) begin : g_wire
      assign q = d;
    end else if (DEPTH == 1) begin : g_one
      logic sr;
      always_ff @(posedge clk) begin
        if (rst) sr <= 1'b0;
        else     sr <= d;
      end
      assign q = sr;
    end else begin : g_many
      logic [DEPTH-1:0] sr;
      always_ff @(posedge clk) begin
        if (rst) sr <= '0;
        else     sr <= {sr[DEPTH-2:0], d};
      end
      assign q = sr[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/en2_level.sv
// rtl/en2_level.sv - rebuilds a level from rise/fall pulses with minimum high/low times
module en2_level
  import en2level_pkg::*;
#(
  parameter int DELAY    = 1,
  parameter int MIN_HIGH = 1,
  parameter int MIN_LOW  = 1
) (
  input logic        clk,
  input logic        rst,
  en2_level_if.slave bus
);

  localparam int CMAX = max2(MIN_HIGH, MIN_LOW);
  localparam int CW   = $clog2(CMAX + 1);

  state_t        state_q, state_d;
  logic          lvl_q, lvl_d;
  logic          pend_q, pend_d;
  logic          err_q, err_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          sat, same, opp, toggle;
  logic          out_w;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LOW;
      lvl_q   <= 1'b0;
      pend_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= CW'(CMAX);
    end else begin
      state_q <= state_d;
      lvl_q   <= lvl_d;
      pend_q  <= pend_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // A pending event is always the opposite of the current level, so one flag suffices.
  always_comb begin
    lvl_d  = lvl_q;
    pend_d = pend_q;
    err_d  = 1'b0;
    toggle = 1'b0;
    sat    = (state_q == LOW) || (state_q == HIGH);
    same   = lvl_q ? bus.en_rise : bus.en_fall;
    opp    = lvl_q ? bus.en_fall : bus.en_rise;

    if (bus.en_rise && bus.en_fall) begin
      err_d  = 1'b1;
      toggle = pend_q && sat;
    end else if (same) begin
      if (pend_q) pend_d = 1'b0;
      else        err_d  = 1'b1;
    end else if (opp) begin
      if (pend_q) begin
        err_d  = 1'b1;
        toggle = sat;
      end else if (sat) begin
        toggle = 1'b1;
      end else begin
        pend_d = 1'b1;
      end
    end else begin
      toggle = pend_q && sat;
    end

    if (toggle) begin
      lvl_d  = ~lvl_q;
      pend_d = 1'b0;
    end

    if (toggle)                  cnt_d = CW'(1);
    else if (cnt_q == CW'(CMAX)) cnt_d = cnt_q;
    else                         cnt_d = cnt_q + CW'(1);

    if (lvl_d) state_d = (cnt_d < CW'(MIN_HIGH)) ? HIGH_HOLD : HIGH;
    else       state_d = (cnt_d < CW'(MIN_LOW))  ? LOW_HOLD  : LOW;
  end

  sync_delay #(.DEPTH(DELAY - 1)) u_delay (
    .clk (clk),
    .rst (rst),
    .d   (lvl_q),
    .q   (out_w)
  );

  assign bus.out  = out_w;
  assign bus.busy = pend_q;
  assign bus.err  = err_q;

endmodule

// File: tb/tb_en2_level.sv
// tb/tb_en2_level.sv - directed self-checking bench for en2_level
module tb_en2_level;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;

  en2_level_if bus_a ();
  en2_level_if bus_b ();

  en2_level #(.DELAY(2), .MIN_HIGH(3), .MIN_LOW(2)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  en2_level #(.DELAY(1), .MIN_HIGH(1), .MIN_LOW(1)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  always #5 clk = ~clk;

  // Cycle c runs from posedge c to posedge c+1; inputs are set at its start, outputs read at its negedge.
  task automatic check_a(input string name, input int c, input logic eo, input logic eb, input logic ee);
    checks++;
    if ({bus_a.out, bus_a.busy, bus_a.err} !== {eo, eb, ee}) begin
      failures++;
      $display("FAIL %s cycle=%0d out/busy/err got=%b%b%b exp=%b%b%b",
               name, c, bus_a.out, bus_a.busy, bus_a.err, eo, eb, ee);
    end
  endtask

  task automatic test_reset();
    for (int c = 0; c < 5; c++) begin
      rst = (c < 2);
      bus_a.en_rise = 1'b0; bus_a.en_fall = 1'b0;
      bus_b.en_rise = 1'b0; bus_b.en_fall = 1'b0;
      @(negedge clk);
      if (c >= 2) begin
        check_a("reset_a", c, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({bus_b.out, bus_b.busy, bus_b.err} !== 3'b000) begin
          failures++;
          $display("FAIL reset_b cycle=%0d got=%b%b%b exp=000", c, bus_b.out, bus_b.busy, bus_b.err);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_rise_fall();
    for (int c = 0; c < 26; c++) begin
      rst = (c < 2);
      bus_a.en_rise = (c == 10);
      bus_a.en_fall = (c == 20);
      @(negedge clk);
      if (c >= 2) check_a("rise_fall", c, (c >= 12 && c <= 21), 1'b0, 1'b0);
      @(posedge clk); #1;
    end
  endtask

  task automatic test_early_fall();
    for (int c = 0; c < 20; c++) begin
      rst = (c < 2);
      bus_a.en_rise = (c == 10);
      bus_a.en_fall = (c == 12);
      @(negedge clk);
      if (c >= 2) check_a("early_fall", c, (c >= 12 && c <= 14), (c == 13), 1'b0);
      @(posedge clk); #1;
    end
  endtask

  task automatic test_cancel();
    for (int c = 0; c < 22; c++) begin
      rst = (c < 2);
      bus_a.en_rise = (c == 10) || (c == 12);
      bus_a.en_fall = (c == 11);
      @(negedge clk);
      if (c >= 2) check_a("cancel", c, (c >= 12), (c == 12), 1'b0);
      @(posedge clk); #1;
    end
  endtask

  task automatic test_conflicts();
    for (int c = 0; c < 45; c++) begin
      rst = (c < 2);
      bus_a.en_rise = (c == 30);
      bus_a.en_fall = (c == 30) || (c == 40);
      @(negedge clk);
      if (c >= 2) check_a("conflicts", c, 1'b0, 1'b0, (c == 31) || (c == 41));
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid();
    for (int c = 0; c < 22; c++) begin
      rst = (c < 2) || (c == 13);
      bus_a.en_rise = (c == 10) || (c == 15);
      bus_a.en_fall = (c == 12);
      @(negedge clk);
      if (c >= 2) check_a("reset_mid", c, (c == 12) || (c == 13) || (c >= 17), (c == 13), 1'b0);
      @(posedge clk); #1;
    end
  endtask

  task automatic test_fast_toggle();
    logic eo;
    for (int c = 0; c < 19; c++) begin
      rst = (c < 2);
      bus_a.en_rise = 1'b0; bus_a.en_fall = 1'b0;
      bus_b.en_rise = (c >= 5 && c <= 14) && ((c - 5) % 2 == 0);
      bus_b.en_fall = (c >= 5 && c <= 14) && ((c - 5) % 2 == 1);
      @(negedge clk);
      if (c >= 2) begin
        eo = (c >= 6 && c <= 15) && ((c - 6) % 2 == 0);
        checks++;
        if ({bus_b.out, bus_b.busy, bus_b.err} !== {eo, 2'b00}) begin
          failures++;
          $display("FAIL fast_toggle cycle=%0d out/busy/err got=%b%b%b exp=%b00",
                   c, bus_b.out, bus_b.busy, bus_b.err, eo);
        end
      end
      @(posedge clk); #1;
    end
    bus_b.en_rise = 1'b0; bus_b.en_fall = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus_a.en_rise = 1'b0; bus_a.en_fall = 1'b0;
    bus_b.en_rise = 1'b0; bus_b.en_fall = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_rise_fall();
    test_early_fall();
    test_cancel();
    test_conflicts();
    test_reset_mid();
    test_fast_toggle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
